// File: rtl/dlx_ctrl.sv
// dlx_ctrl: multi-cycle DLX control FSM sequencing fetch, decode, execute, memory and write-back.
module dlx_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        i_ready,
  input  logic        d_ready,
  input  logic [31:0] rs1_val,
  output logic        i_req,
  output logic        IF,
  output logic [1:0]  pc_cmd,
  output logic [31:0] pc_v,
  output logic        d_read,
  output logic        d_write,
  output logic        rf_we,
  output logic [31:0] ir,
  output logic [2:0]  state,
  output logic        halt,
  output logic [31:0] retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} st_t;
  st_t st, exec_nxt;
  logic [5:0] op;
  logic is_j, is_jal, is_beqz, is_bnez, is_jr, is_jalr, is_lw, is_sw, is_trap;
  logic taken, exec_if, reg_tgt, ret;
  assign op      = ir[31:26];
  assign is_j    = op == 6'h02;
  assign is_jal  = op == 6'h03;
  assign is_beqz = op == 6'h04;
  assign is_bnez = op == 6'h05;
  assign is_jr   = op == 6'h12;
  assign is_jalr = op == 6'h13;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_trap = op == 6'h3F;
  assign taken   = (is_beqz && rs1_val == 32'd0) || (is_bnez && rs1_val != 32'd0);
  assign reg_tgt = is_jr || is_jalr;
  assign exec_if = is_j || is_jal || taken || reg_tgt;
  assign state   = st;
  assign halt    = st == HALT;
  // Strobes depend on the same-cycle handshake inputs, so they are combinational off the registered state.
  always_comb begin
    exec_nxt = (is_lw || is_sw) ? MEM : is_trap ? HALT :
               (is_j || is_beqz || is_bnez || is_jr) ? FETCH : WB;
    ret      = (st == EXEC && exec_nxt != MEM && exec_nxt != WB) ||
               (st == MEM && d_ready && is_sw) || st == WB;
    i_req    = !reset && st == FETCH;
    IF       = !reset && (st == FETCH ? i_ready : st == EXEC && exec_if);
    pc_cmd   = (!IF || st == FETCH) ? 2'b00 : reg_tgt ? 2'b11 : 2'b10;
    pc_v     = (!IF || st == FETCH) ? 32'd0 : reg_tgt ? rs1_val :
               (is_j || is_jal) ? {{6{ir[25]}}, ir[25:0]} : {{16{ir[15]}}, ir[15:0]};
    d_read   = !reset && st == MEM && is_lw;
    d_write  = !reset && st == MEM && is_sw;
    rf_we    = !reset && st == WB;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= FETCH;
      ir      <= 32'd0;
      retired <= 32'd0;
    end else begin
      retired <= retired + {31'd0, ret};
      case (st)
        FETCH:  if (i_ready) begin
                  ir <= instr;
                  st <= DECODE;
                end
        DECODE: st <= EXEC;
        EXEC:   st <= exec_nxt;
        MEM:    if (d_ready) st <= is_lw ? WB : FETCH;
        WB:     st <= FETCH;
        default: st <= st;
      endcase
    end
  end
endmodule

// File: tb/tb_dlx_ctrl.sv
// tb_dlx_ctrl: per-instruction transaction model of the DLX control sequence with random handshakes.
module tb_dlx_ctrl;
  logic clk = 0, reset = 1, i_ready = 0, d_ready = 0;
  logic [31:0] instr = 0, rs1_val = 0;
  logic i_req, IF, d_read, d_write, rf_we, halt;
  logic [1:0] pc_cmd;
  logic [31:0] pc_v, ir, retired;
  logic [2:0] state;
  int errors = 0, checks = 0;
  logic [31:0] exp_ret = 0;

  dlx_ctrl dut (.clk(clk), .reset(reset), .instr(instr), .i_ready(i_ready), .d_ready(d_ready),
    .rs1_val(rs1_val), .i_req(i_req), .IF(IF), .pc_cmd(pc_cmd), .pc_v(pc_v), .d_read(d_read),
    .d_write(d_write), .rf_we(rf_we), .ir(ir), .state(state), .halt(halt), .retired(retired));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic strobes(input string tag, input bit ireq, input bit ifp, input bit rd, input bit wr, input bit we);
    chk({tag, ".i_req"}, 32'(i_req), 32'(ireq));
    chk({tag, ".IF"}, 32'(IF), 32'(ifp));
    chk({tag, ".d_read"}, 32'(d_read), 32'(rd));
    chk({tag, ".d_write"}, 32'(d_write), 32'(wr));
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
    if (!ifp) chk({tag, ".pc_v"}, pc_v, 32'd0);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Runs one instruction from FETCH; returns with the DUT back in FETCH (or in HALT for a trap).
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] rs1, input int waitf, input int waitm);
    logic [5:0] op;
    bit jump, branch, take, regj, lw, sw, wb;
    logic [31:0] tgt;
    op = ins[31:26];
    for (int k = 0; k < waitf; k++) begin
      i_ready = 0; instr = $urandom; d_ready = 1'($urandom);
      #1;
      chk("fetch_wait.state", 32'(state), 0);
      chk("fetch_wait.retired", retired, exp_ret);
      strobes("fetch_wait", 1, 0, 0, 0, 0);
      next_cycle();
    end
    i_ready = 1; instr = ins; d_ready = 0;
    #1;
    chk("fetch.state", 32'(state), 0);
    chk("fetch.retired", retired, exp_ret);
    strobes("fetch", 1, 1, 0, 0, 0);
    chk("fetch.pc_cmd", 32'(pc_cmd), 0);
    chk("fetch.pc_v", pc_v, 0);
    next_cycle();
    i_ready = 1'($urandom); instr = $urandom; d_ready = 1'($urandom);
    #1;
    chk("decode.state", 32'(state), 1);
    chk("decode.ir", ir, ins);
    strobes("decode", 0, 0, 0, 0, 0);
    next_cycle();
    rs1_val = rs1; d_ready = 0;
    jump = op == 6'h02 || op == 6'h03;
    branch = op == 6'h04 || op == 6'h05;
    regj = op == 6'h12 || op == 6'h13;
    lw = op == 6'h23; sw = op == 6'h2B;
    take = jump || regj || (op == 6'h04 && rs1 == 0) || (op == 6'h05 && rs1 != 0);
    tgt = regj ? rs1 : jump ? {{6{ins[25]}}, ins[25:0]} : {{16{ins[15]}}, ins[15:0]};
    #1;
    chk("exec.state", 32'(state), 2);
    strobes("exec", 0, take, 0, 0, 0);
    if (take) begin
      chk("exec.pc_cmd", 32'(pc_cmd), regj ? 3 : 2);
      chk("exec.pc_v", pc_v, tgt);
    end
    next_cycle();
    if (op == 6'h3F) begin
      exp_ret++;
      for (int k = 0; k < 6; k++) begin
        i_ready = 1'($urandom); d_ready = 1'($urandom); instr = $urandom;
        #1;
        chk("halt.state", 32'(state), 5);
        chk("halt.halt", 32'(halt), 1);
        chk("halt.retired", retired, exp_ret);
        strobes("halt", 0, 0, 0, 0, 0);
        next_cycle();
      end
      return;
    end
    if (lw || sw) begin
      for (int k = 0; k <= waitm; k++) begin
        d_ready = k == waitm; i_ready = 1'($urandom);
        #1;
        chk("mem.state", 32'(state), 3);
        strobes("mem", 0, 0, lw, sw, 0);
        next_cycle();
      end
      d_ready = 0;
    end
    wb = !(jump || branch || regj || sw) || op == 6'h03 || op == 6'h13;
    if (wb) begin
      #1;
      chk("wb.state", 32'(state), 4);
      strobes("wb", 0, 0, 0, 0, 1);
      next_cycle();
    end
    exp_ret++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [10] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h12, 6'h13, 6'h23, 6'h2B, 6'h00, 6'h0C};
    logic [5:0] op;
    op = ops[$urandom_range(0, 9)];
    if (op == 6'h0C) op = 6'($urandom_range(6, 6'h22));
    return {op, 26'($urandom)};
  endfunction

  initial begin
    i_ready = 1; d_ready = 1;
    next_cycle();
    #1;
    strobes("in_reset", 0, 0, 0, 0, 0);
    next_cycle();
    reset = 0; i_ready = 0; d_ready = 0;
    #1;
    chk("rst.state", 32'(state), 0);
    chk("rst.ir", ir, 0);
    chk("rst.retired", retired, 0);
    chk("rst.halt", 32'(halt), 0);
    chk("rst.i_req", 32'(i_req), 1);
    run_instr(32'h00000020, 0, 0, 0);
    run_instr(32'h1000FFF8, 0, 1, 0);
    run_instr(32'h1000FFF8, 5, 0, 0);
    run_instr(32'h48000000, 32'h00001000, 2, 0);
    run_instr(32'h8C000000, 0, 0, 3);
    run_instr(32'hAC000000, 0, 0, 1);
    for (int n = 0; n < 60; n++)
      run_instr(rand_instr(), ($urandom_range(0, 3) == 0) ? 0 : $urandom, $urandom_range(0, 3), $urandom_range(0, 4));
    i_ready = 1; instr = 32'h8C001234;
    next_cycle();
    i_ready = 0;
    next_cycle();
    rs1_val = $urandom;
    next_cycle();
    d_ready = 0;
    next_cycle();
    #1;
    chk("pre_rst.state", 32'(state), 3);
    chk("pre_rst.d_read", 32'(d_read), 1);
    reset = 1;
    #1;
    strobes("mem_reset", 0, 0, 0, 0, 0);
    next_cycle();
    reset = 0;
    #1;
    exp_ret = 0;
    chk("post_rst.state", 32'(state), 0);
    chk("post_rst.retired", retired, 0);
    chk("post_rst.ir", ir, 0);
    strobes("post_rst", 1, 0, 0, 0, 0);
    next_cycle();
    run_instr(32'h00000020, 0, 0, 0);
    run_instr(32'hFC000000, 0, 0, 0);
    reset = 1;
    next_cycle();
    reset = 0;
    #1;
    chk("halt_rst.state", 32'(state), 0);
    chk("halt_rst.halt", 32'(halt), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
